// File: rtl/forprop_engine.sv
// forprop_engine: single fully-connected layer forward pass with argmax over CLASSES.
// Define FORPROP_SAT_EN to make the accumulator saturate instead of wrapping.
module forprop_engine #(
  parameter int IMG_SIZE = 256,
  parameter int CLASSES  = 10,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_forprop,
  output logic                                  forprop_done,
  output logic                                  busy,
  output logic                                  rd_en,
  output logic [$clog2(IMG_SIZE)-1:0]           px_addr,
  output logic [$clog2(IMG_SIZE*CLASSES)-1:0]   w_addr,
  input  logic [DATA_W-1:0]                     px_data,
  input  logic [DATA_W-1:0]                     w_data,
  output logic [$clog2(CLASSES)-1:0]            pred_class,
  output logic [ACC_W-1:0]                      pred_score,
  output logic                                  pred_valid
);

  localparam int PX_W   = $clog2(IMG_SIZE);
  localparam int WA_W   = $clog2(IMG_SIZE*CLASSES);
  localparam int C_W    = $clog2(CLASSES);
  localparam int PROD_W = 2*DATA_W + 1;
  localparam logic [PX_W-1:0] LAST_PX = PX_W'(IMG_SIZE-1);
  localparam logic [C_W-1:0]  LAST_C  = C_W'(CLASSES-1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [C_W-1:0]           c;
  logic [C_W-1:0]           best_idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  best;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     mac_vld;
  logic                     last_px;
  logic                     last_c;
  logic                     take;

  assign last_px = (px_addr == LAST_PX);
  assign last_c  = (c == LAST_C);
  // Class 0 always seeds best; later classes must be strictly greater so ties keep the lower index.
  assign take    = (c == C_W'(0)) || (acc > best);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_forprop) state_next = MAC;
               else               state_next = IDLE;
      MAC:     if (last_px) state_next = DRAIN;
               else         state_next = MAC;
      DRAIN:   state_next = CMP;
      CMP:     if (last_c) state_next = DONE;
               else        state_next = MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pixel is unsigned, weight signed; the product fits exactly in PROD_W signed bits.
  always_comb begin
    prod     = $signed(PROD_W'({1'b0, px_data})) * PROD_W'($signed(w_data));
    prod_ext = ACC_W'(prod);
  end

`ifdef FORPROP_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_wide;

  // One guard bit exposes overflow; clamp to the rail in the direction of the overflow.
  always_comb begin
    sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      if (sum_wide[ACC_W]) acc_sum = ACC_MIN;
      else                 acc_sum = ACC_MAX;
    end else begin
      acc_sum = sum_wide[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    acc_sum = acc + prod_ext;
  end
`endif

  // Outputs are registered from the next state so none depends combinationally on inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      forprop_done <= 1'b0;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      px_addr      <= '0;
      w_addr       <= '0;
      pred_class   <= '0;
      pred_score   <= '0;
      pred_valid   <= 1'b0;
      c            <= '0;
      best_idx     <= '0;
      acc          <= '0;
      best         <= '0;
      mac_vld      <= 1'b0;
    end else begin
      busy         <= (state_next != IDLE);
      rd_en        <= (state_next == MAC);
      forprop_done <= (state == DONE);
      // Read data returns one cycle after rd_en, so the delayed strobe marks a valid product.
      mac_vld      <= rd_en;
      case (state)
        IDLE: begin
          if (start_forprop) begin
            acc        <= '0;
            c          <= '0;
            px_addr    <= '0;
            w_addr     <= '0;
            pred_valid <= 1'b0;
          end
        end
        MAC: begin
          if (mac_vld) acc <= acc_sum;
          if (!last_px) begin
            px_addr <= px_addr + PX_W'(1);
            w_addr  <= w_addr + WA_W'(1);
          end
        end
        DRAIN: begin
          if (mac_vld) acc <= acc_sum;
        end
        CMP: begin
          if (take) begin
            best     <= acc;
            best_idx <= c;
          end
          if (last_c) begin
            pred_class <= take ? c : best_idx;
            pred_score <= take ? acc : best;
            pred_valid <= 1'b1;
          end else begin
            // Weight rows are contiguous, so the next row starts right after this one.
            c       <= c + C_W'(1);
            px_addr <= '0;
            w_addr  <= w_addr + WA_W'(1);
            acc     <= '0;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
